// File: rtl/tb_ethernet_transmitter.sv
// Ethernet reply transmitter: serialises a 42-byte reply header plus an
// optional payload stream onto a 64-bit AXI-Stream toward the MAC. The payload
// is realigned by 6 bytes so it follows header bytes 40-41, and short frames
// can be zero-padded up to MIN_FRAME bytes.
//
// Handshake rule on every stream: a beat transfers on a rising edge where
// valid && ready are both high. Once valid is raised, data/keep/last do not
// change and valid does not drop until that transfer happens.
module tb_ethernet_transmitter #(
  parameter int MIN_FRAME = 60,
  parameter bit PAD_EN    = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [335:0] i_data_head_reply,
  input  logic         i_data_head_reply_valid,
  input  logic         i_has_payload,
  output logic         o_data_head_reply_ready,
  input  logic         i_pl_tvalid,
  input  logic [63:0]  i_pl_tdata,
  input  logic [7:0]   i_pl_tkeep,
  input  logic         i_pl_tlast,
  output logic         o_pl_tready,
  output logic         o_tx_axis_tvalid,
  output logic [63:0]  o_tx_axis_tdata,
  output logic [7:0]   o_tx_axis_tkeep,
  output logic         o_tx_axis_tlast,
  input  logic         i_tx_axis_tready,
  output logic         o_busy,
  output logic [2:0]   o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    JOIN    = 3'd2,
    PAYLOAD = 3'd3,
    RESID   = 3'd4,
    PAD     = 3'd5
  } state_t;

  state_t         state_q;
  logic [335:0]   hdr_q;
  logic           has_pl_q;
  logic [2:0]     beat_q;
  logic [15:0]    held_q;      // lanes 6-7 of the previous payload beat
  logic [1:0]     held_cnt_q;  // valid bytes in held_q when draining in RESID
  logic [15:0]    byte_cnt_q;  // frame bytes emitted so far
  logic           tvalid_q;
  logic [63:0]    tdata_q;
  logic [7:0]     tkeep_q;
  logic           tlast_q;
  logic           busy_q;

  logic           slot_free;
  logic [335:0]   hdr_sh;
  logic [3:0]     pl_n;
  logic [63:0]    cand_data;
  logic [3:0]     cand_k;
  logic           cand_final;
  logic [15:0]    total_d;
  logic [15:0]    pad_rem_d;
  logic [7:0]     data_mask;
  logic [63:0]    emit_data_d;
  logic [7:0]     emit_keep_d;
  logic           emit_last_d;
  logic           emit_pad_d;
  logic [3:0]     emit_n_d;

  function automatic logic [7:0] lane_mask(input logic [3:0] n);
    if (n >= 4'd8) return 8'hFF;
    return 8'((9'd1 << n) - 9'd1);
  endfunction

  function automatic logic [3:0] keep_count(input logic [7:0] k);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, k[i]};
    return c;
  endfunction

  assign slot_free = !tvalid_q || i_tx_axis_tready;

  // Build the candidate output beat for the current state, then apply padding/tlast rules.
  always_comb begin
    hdr_sh     = hdr_q << {beat_q, 6'd0};
    pl_n       = keep_count(i_pl_tkeep);
    cand_data  = '0;
    cand_k     = 4'd0;
    cand_final = 1'b0;
    case (state_q)
      HDR: begin
        for (int j = 0; j < 8; j++) cand_data[8*j +: 8] = hdr_sh[335 - 8*j -: 8];
        cand_k = 4'd8;
      end
      JOIN, PAYLOAD: begin
        cand_data = {i_pl_tdata[47:0],
                     (state_q == JOIN) ? {hdr_q[7:0], hdr_q[15:8]} : held_q};
        if (i_pl_tlast && pl_n <= 4'd6) begin
          cand_k     = pl_n + 4'd2;
          cand_final = 1'b1;
        end else begin
          cand_k = 4'd8;
        end
      end
      RESID: begin
        cand_data  = {48'd0, held_q};
        cand_k     = {2'b00, held_cnt_q};
        cand_final = 1'b1;
      end
      PAD: cand_final = 1'b1;
      default: ;
    endcase

    total_d   = byte_cnt_q + {12'd0, cand_k};
    pad_rem_d = 16'(MIN_FRAME) - byte_cnt_q;
    data_mask = lane_mask(cand_k);
    emit_data_d = cand_data;
    for (int j = 0; j < 8; j++) if (!data_mask[j]) emit_data_d[8*j +: 8] = 8'd0;

    emit_keep_d = 8'hFF;
    emit_last_d = 1'b0;
    emit_pad_d  = 1'b0;
    emit_n_d    = 4'd8;
    if (cand_final && PAD_EN && total_d < 16'(MIN_FRAME)) begin
      if (pad_rem_d > 16'd8) begin
        emit_pad_d = 1'b1;
      end else begin
        emit_keep_d = lane_mask(pad_rem_d[3:0]);
        emit_last_d = 1'b1;
        emit_n_d    = pad_rem_d[3:0];
      end
    end else if (cand_final) begin
      emit_keep_d = data_mask;
      emit_last_d = 1'b1;
      emit_n_d    = cand_k;
    end
  end

  // Frame FSM with registered output beat; PAD also serves as the tail state waiting for tlast acceptance.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      hdr_q      <= '0;
      has_pl_q   <= 1'b0;
      beat_q     <= 3'd0;
      held_q     <= 16'd0;
      held_cnt_q <= 2'd0;
      byte_cnt_q <= 16'd0;
      tvalid_q   <= 1'b0;
      tdata_q    <= 64'd0;
      tkeep_q    <= 8'd0;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else if (state_q == IDLE) begin
      if (i_data_head_reply_valid) begin
        hdr_q      <= i_data_head_reply;
        has_pl_q   <= i_has_payload;
        beat_q     <= 3'd0;
        held_q     <= 16'd0;
        held_cnt_q <= 2'd0;
        byte_cnt_q <= 16'd0;
        busy_q     <= 1'b1;
        state_q    <= HDR;
      end
    end else if (slot_free) begin
      if (tvalid_q && tlast_q) begin
        tvalid_q   <= 1'b0;
        tlast_q    <= 1'b0;
        tdata_q    <= 64'd0;
        tkeep_q    <= 8'd0;
        busy_q     <= 1'b0;
        byte_cnt_q <= 16'd0;
        state_q    <= IDLE;
      end else if ((state_q == JOIN || state_q == PAYLOAD) && !i_pl_tvalid) begin
        tvalid_q <= 1'b0;
      end else begin
        tvalid_q   <= 1'b1;
        tdata_q    <= emit_data_d;
        tkeep_q    <= emit_keep_d;
        tlast_q    <= emit_last_d;
        byte_cnt_q <= byte_cnt_q + {12'd0, emit_n_d};
        case (state_q)
          HDR: begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'd4) begin
              if (has_pl_q) begin
                state_q <= JOIN;
              end else begin
                held_q     <= {hdr_q[7:0], hdr_q[15:8]};
                held_cnt_q <= 2'd2;
                state_q    <= RESID;
              end
            end
          end
          JOIN, PAYLOAD: begin
            held_q <= i_pl_tdata[63:48];
            if (emit_last_d || emit_pad_d) begin
              state_q <= PAD;
            end else if (i_pl_tlast) begin
              held_cnt_q <= 2'(pl_n - 4'd6);
              state_q    <= RESID;
            end else begin
              state_q <= PAYLOAD;
            end
          end
          default: state_q <= PAD;
        endcase
      end
    end
  end

  assign o_data_head_reply_ready = (state_q == IDLE);
  assign o_pl_tready      = (state_q == JOIN || state_q == PAYLOAD) && slot_free;
  assign o_tx_axis_tvalid = tvalid_q;
  assign o_tx_axis_tdata  = tdata_q;
  assign o_tx_axis_tkeep  = tkeep_q;
  assign o_tx_axis_tlast  = tlast_q;
  assign o_busy           = busy_q;
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_tb_ethernet_transmitter.sv
// Bench for tb_ethernet_transmitter: a padding instance driven with directed and
// random frames, and a no-padding instance with its header offer held high.
// Expected beats come from a byte-list frame model chunked into 8-byte beats.
module tb_tb_ethernet_transmitter;
  localparam int MIN = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // padding instance
  logic [335:0] hdr = '0;
  logic         hv = 1'b0, hp = 1'b0, rdy;
  logic         pl_tvalid = 1'b0, pl_tlast = 1'b0, pl_tready;
  logic [63:0]  pl_tdata = '0;
  logic [7:0]   pl_tkeep = '0;
  logic         tx_tvalid, tx_tlast, tx_tready = 1'b1, busy;
  logic [63:0]  tx_tdata;
  logic [7:0]   tx_tkeep;
  logic [2:0]   dbg;

  // no-padding instance
  logic [335:0] b_hdr = '0;
  logic         b_hv = 1'b0, b_hp = 1'b0, b_rdy;
  logic         b_pl_tvalid = 1'b0, b_pl_tlast = 1'b0, b_pl_tready;
  logic [63:0]  b_pl_tdata = '0;
  logic [7:0]   b_pl_tkeep = '0;
  logic         b_tvalid, b_tlast, b_tready = 1'b1, b_busy;
  logic [63:0]  b_tdata;
  logic [7:0]   b_tkeep;
  logic [2:0]   b_dbg;

  int checks = 0, failures = 0;
  logic [72:0] exp_q[$];
  logic [72:0] b_exp_q[$];
  logic [7:0]  pl_bytes[$];
  bit rnd_ready = 1'b0;

  tb_ethernet_transmitter #(.MIN_FRAME(MIN), .PAD_EN(1'b1)) u_dut (
    .i_clk(clk), .i_reset(rst),
    .i_data_head_reply(hdr), .i_data_head_reply_valid(hv), .i_has_payload(hp),
    .o_data_head_reply_ready(rdy),
    .i_pl_tvalid(pl_tvalid), .i_pl_tdata(pl_tdata), .i_pl_tkeep(pl_tkeep),
    .i_pl_tlast(pl_tlast), .o_pl_tready(pl_tready),
    .o_tx_axis_tvalid(tx_tvalid), .o_tx_axis_tdata(tx_tdata), .o_tx_axis_tkeep(tx_tkeep),
    .o_tx_axis_tlast(tx_tlast), .i_tx_axis_tready(tx_tready),
    .o_busy(busy), .o_dbg_state(dbg)
  );

  tb_ethernet_transmitter #(.MIN_FRAME(MIN), .PAD_EN(1'b0)) u_dut_nopad (
    .i_clk(clk), .i_reset(rst),
    .i_data_head_reply(b_hdr), .i_data_head_reply_valid(b_hv), .i_has_payload(b_hp),
    .o_data_head_reply_ready(b_rdy),
    .i_pl_tvalid(b_pl_tvalid), .i_pl_tdata(b_pl_tdata), .i_pl_tkeep(b_pl_tkeep),
    .i_pl_tlast(b_pl_tlast), .o_pl_tready(b_pl_tready),
    .o_tx_axis_tvalid(b_tvalid), .o_tx_axis_tdata(b_tdata), .o_tx_axis_tkeep(b_tkeep),
    .o_tx_axis_tlast(b_tlast), .i_tx_axis_tready(b_tready),
    .o_busy(b_busy), .o_dbg_state(b_dbg)
  );

  task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s got=timeout exp=completion @%0t", nm, $time);
  endtask

  function automatic logic [335:0] rand_hdr();
    logic [335:0] h;
    for (int k = 0; k < 42; k++) h[8*k +: 8] = 8'($urandom_range(0, 255));
    return h;
  endfunction

  // Reference: frame = header bytes, payload bytes, zero pad to MIN; cut into 8-byte beats.
  task automatic model_frame(input logic [335:0] h, input bit pad_en, input bit to_b);
    logic [7:0]  fr[$];
    logic [63:0] d;
    logic [7:0]  k;
    logic [72:0] e;
    for (int i = 0; i < 42; i++) fr.push_back(h[335 - 8*i -: 8]);
    foreach (pl_bytes[i]) fr.push_back(pl_bytes[i]);
    while (pad_en && fr.size() < MIN) fr.push_back(8'h00);
    for (int b = 0; b < fr.size(); b += 8) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 8; j++) begin
        if (b + j < fr.size()) begin
          d[8*j +: 8] = fr[b + j];
          k[j] = 1'b1;
        end
      end
      e = {(b + 8 >= fr.size()), k, d};
      if (to_b) b_exp_q.push_back(e);
      else exp_q.push_back(e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_header(input logic [335:0] h, input bit has);
    bit acc;
    acc = 1'b0;
    hdr = h;
    hp  = has;
    hv  = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      acc = rdy;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    hv = 1'b0;
    if (!acc) note_fail("hdr_accept");
    hdr = rand_hdr();               // later input changes must not leak into the frame
    hp  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_payload(input int plen, input bit gaps);
    int nb;
    bit acc;
    logic [63:0] d;
    logic [7:0]  k;
    nb = (plen + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      if (gaps) begin
        pl_tvalid = 1'b0;
        pl_tdata  = {$urandom, $urandom};
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      d = '0;
      k = '0;
      for (int j = 0; j < 8; j++) begin
        if (8*b + j < plen) begin
          d[8*j +: 8] = pl_bytes[8*b + j];
          k[j] = 1'b1;
        end
      end
      pl_tdata  = d;
      pl_tkeep  = k;
      pl_tlast  = (b == nb - 1);
      pl_tvalid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        acc = pl_tready;
        @(posedge clk);
        #1;
        if (acc) break;
      end
      if (!acc) begin
        note_fail("pl_handshake");
        break;
      end
    end
    pl_tvalid = 1'b0;
    pl_tlast  = 1'b0;
    pl_tdata  = {$urandom, $urandom};
  endtask

  task automatic wait_idle(input bit is_b);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (is_b ? (b_exp_q.size() == 0 && !b_busy) : (exp_q.size() == 0 && !busy)) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) note_fail(is_b ? "frame_done_nopad" : "frame_done");
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int plen, input bit rr, input bit gaps);
    logic [335:0] h;
    h = rand_hdr();
    rnd_ready = rr;
    pl_bytes.delete();
    for (int i = 0; i < plen; i++) pl_bytes.push_back(8'($urandom_range(0, 255)));
    model_frame(h, 1'b1, 1'b0);
    fork
      send_header(h, plen > 0);
      send_payload(plen, gaps);
    join
    wait_idle(1'b0);
  endtask

  // MAC-side ready: always high or ~50% random for the padding instance, random for the other
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      b_tready  = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- scoreboard monitors ----------------
  logic [72:0] sav_a, sav_b;
  bit stall_a = 1'b0, stall_b = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_a = 1'b0;
    end else begin
      if (busy) chk("rdy_low_while_busy", {72'd0, rdy}, 73'd0);
      if (stall_a) begin
        chk("stall_valid_held", {72'd0, tx_tvalid}, 73'd1);
        chk("stall_beat_held", {tx_tlast, tx_tkeep, tx_tdata}, sav_a);
      end
      stall_a = 1'b0;
      if (tx_tvalid) begin
        if (tx_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL beat_unexpected got=%h exp=none @%0t", {tx_tlast, tx_tkeep, tx_tdata}, $time);
          end else begin
            chk("beat", {tx_tlast, tx_tkeep, tx_tdata}, exp_q.pop_front());
          end
        end else begin
          stall_a = 1'b1;
          sav_a = {tx_tlast, tx_tkeep, tx_tdata};
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_b = 1'b0;
    end else begin
      if (b_busy) chk("nopad_rdy_low_while_busy", {72'd0, b_rdy}, 73'd0);
      if (stall_b) begin
        chk("nopad_stall_valid_held", {72'd0, b_tvalid}, 73'd1);
        chk("nopad_stall_beat_held", {b_tlast, b_tkeep, b_tdata}, sav_b);
      end
      stall_b = 1'b0;
      if (b_tvalid) begin
        if (b_tready) begin
          if (b_exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL nopad_beat_unexpected got=%h exp=none @%0t", {b_tlast, b_tkeep, b_tdata}, $time);
          end else begin
            chk("nopad_beat", {b_tlast, b_tkeep, b_tdata}, b_exp_q.pop_front());
          end
        end else begin
          stall_b = 1'b1;
          sav_b = {b_tlast, b_tkeep, b_tdata};
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [335:0] h, h1, h2;
    int n_acc, plen;
    bit acc;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", {72'd0, tx_tvalid}, 73'd0);
    chk("rst_out_beat", {tx_tlast, tx_tkeep, tx_tdata}, 73'd0);
    chk("rst_busy", {72'd0, busy}, 73'd0);
    chk("rst_hdr_ready", {72'd0, rdy}, 73'd1);
    chk("rst_pl_tready", {72'd0, pl_tready}, 73'd0);
    chk("rst_nopad_ready", {72'd0, b_rdy}, 73'd1);
    @(posedge clk);
    #1;

    run_frame(0, 1'b0, 1'b0);    // ARP header only, padded to 60
    run_frame(32, 1'b0, 1'b0);   // 74-byte frame
    run_frame(17, 1'b0, 1'b0);   // 59 data bytes, one pad byte
    run_frame(32, 1'b1, 1'b0);   // 74-byte frame under MAC backpressure

    // reset while beat 3 is on the bus
    rnd_ready = 1'b0;
    h = rand_hdr();
    pl_bytes.delete();
    model_frame(h, 1'b1, 1'b0);
    send_header(h, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_tvalid", {72'd0, tx_tvalid}, 73'd0);
    chk("abort_tlast", {72'd0, tx_tlast}, 73'd0);
    chk("abort_busy", {72'd0, busy}, 73'd0);
    chk("abort_hdr_ready", {72'd0, rdy}, 73'd1);
    @(posedge clk);
    #1;
    run_frame(0, 1'b0, 1'b0);    // clean ARP frame after the abort

    // boundary payload lengths: exact 60, last beat n=6/7/8, single byte, long
    run_frame(18, 1'b0, 1'b0);
    run_frame(14, 1'b1, 1'b1);
    run_frame(15, 1'b1, 1'b1);
    run_frame(16, 1'b1, 1'b1);
    run_frame(1, 1'b1, 1'b0);
    run_frame(39, 1'b0, 1'b1);
    run_frame(64, 1'b1, 1'b1);

    for (int f = 0; f < 20; f++) begin
      plen = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 100));
      run_frame(plen, 1'b1, 1'b1);
    end

    // no-padding instance: header offer held high across two frames
    h1 = rand_hdr();
    h2 = rand_hdr();
    pl_bytes.delete();
    model_frame(h1, 1'b0, 1'b1);
    model_frame(h2, 1'b0, 1'b1);
    b_hdr = h1;
    b_hv  = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 1000 && n_acc < 2; c++) begin
      @(negedge clk);
      acc = b_rdy;
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        if (n_acc == 1) b_hdr = h2;
        else b_hv = 1'b0;
      end
    end
    chk("nopad_accept_count", 73'(n_acc), 73'd2);
    wait_idle(1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("nopad_idle_after", {72'd0, b_busy}, 73'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tb_ethernet_transmitter.md
TB_ETHERNET_TRANSMITTER -- requirements
Module: tb_ethernet_transmitter

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 60, meaning minimum frame length in bytes excluding FCS; shorter frames zero-padded.
REQ-002 SHALL have parameter PAD_EN, default 1, meaning 1 = apply MIN_FRAME padding, 0 = no padding.
REQ-003 i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_data_head_reply  input  336  42-byte reply header; header byte k = bits [335-8k -: 8].
REQ-006 i_data_head_reply_valid  input  1  header offer; accepted when high with o_data_head_reply_ready.
REQ-007 i_has_payload  input  1  sampled with header; 1 = payload stream follows header.
REQ-008 o_data_head_reply_ready  output  1  high only in IDLE.
REQ-009 i_pl_tvalid / i_pl_tdata[63:0] / i_pl_tkeep[7:0] / i_pl_tlast  input  payload AXI-Stream; lane j = tdata[8j+7:8j], lane 0 first; keep contiguous from lane 0, partial only on tlast beat.
REQ-010 o_pl_tready  output  1  payload beat consumed when i_pl_tvalid && o_pl_tready.
REQ-011 o_tx_axis_tvalid / o_tx_axis_tdata[63:0] / o_tx_axis_tkeep[7:0] / o_tx_axis_tlast  output  frame stream to MAC, same lane order.
REQ-012 i_tx_axis_tready  input  1  MAC accepts beat when high with o_tx_axis_tvalid.
REQ-013 o_busy  output  1  high from header acceptance until final beat accepted.

Function
REQ-014 SHALL latch header and i_has_payload on acceptance; o_tx_axis_tvalid for beat 0 asserted the following cycle.
REQ-015 SHALL hold all o_tx_axis_* stable while tvalid && !tready.
REQ-016 Output register SHALL advance only when !o_tx_axis_tvalid || i_tx_axis_tready ("slot free").
REQ-017 FSM states: IDLE, HDR, JOIN, PAYLOAD, RESID, PAD.
REQ-018 IDLE -> HDR on header acceptance; HDR emits beats 0-4 = header bytes 0-39 (keep 0xFF), beat counter 0..4.
REQ-019 After beat 4: JOIN if has_payload, else PAD (PAD_EN=1) or final beat with lanes 0-1 = header bytes 40-41, keep 0x03, tlast (PAD_EN=0).
REQ-020 JOIN: lanes 0-1 = header bytes 40-41, lanes 2-7 = payload lanes 0-5; consumes one payload beat.
REQ-021 PAYLOAD: lanes 0-1 = held lanes 6-7 of previous payload beat, lanes 2-7 = current lanes 0-5 (fixed 6-byte realignment).
REQ-022 o_pl_tready = (state JOIN or PAYLOAD) && slot free; zero in all other states.
REQ-023 On payload tlast with valid byte count n: if n <= 6, that output beat is the last payload beat; if n > 6, go RESID, emitting n-6 held bytes in lanes 0..n-7.
REQ-024 SHALL maintain 16-bit byte counter of emitted frame bytes; tkeep of final beat = contiguous mask of remaining bytes.
REQ-025 If PAD_EN=1 and total < MIN_FRAME: unused lanes of last data beat and subsequent PAD beats zero-filled until MIN_FRAME bytes; tlast on beat containing byte MIN_FRAME-1.
REQ-026 Total >= MIN_FRAME: tlast on beat containing final data byte; no padding.
REQ-027 Payload stall (i_pl_tvalid low) in JOIN/PAYLOAD SHALL deassert o_tx_axis_tvalid after current beat accepted; no bubble data emitted.
REQ-028 Return to IDLE the cycle after tlast beat accepted; new header acceptable that cycle (o_data_head_reply_ready high).
REQ-029 Header offered while busy SHALL be ignored (ready low); never corrupts frame in progress.
REQ-030 Inputs changing after acceptance SHALL NOT affect frame in progress.

Reset
REQ-031 On i_reset: state IDLE; o_tx_axis_tvalid/tlast 0, tdata 0, tkeep 0; o_pl_tready 0; o_busy 0; counters and held bytes 0; o_data_head_reply_ready 1 the cycle after reset deasserts.
REQ-032 Reset mid-frame SHALL abort immediately without tlast; partial frame is not resumed.

Verification
REQ-033 ARP header only, has_payload=0, tready=1 -> 8 beats: 0-4 header, beat 5 lanes 0-1 bytes 40-41 rest 0, beat 6 zero keep 0xFF, beat 7 zero keep 0x0F tlast; 60 bytes.
REQ-034 ICMP, 32-byte payload (4 beats keep 0xFF), tready=1 -> 74 bytes: beats 0-8 keep 0xFF, beat 9 keep 0x03 tlast = payload bytes 30-31; every byte in order.
REQ-035 Payload 17 bytes (keep 0xFF,0xFF,0x01) -> 59 data bytes padded: beat 7 keep 0x0F tlast, byte 59 = 0x00.
REQ-036 Random tready (~50%) on 74-byte frame -> tdata/tkeep/tlast stable while stalled, byte stream identical to REQ-034.
REQ-037 i_reset during beat 3 -> next cycle tvalid 0, busy 0; following ARP frame matches REQ-033 exactly.
REQ-038 Header valid held high through frame, PAD_EN=0, header only -> one frame of 6 beats, final keep 0x03, second frame starts only after tlast accepted.
